pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic inter-stage pipeline register for the RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a control bundle and a data bundle with a valid/ready handshake, hazard-unit stall and flush.
//  Control bits read as zero whenever no valid entry is held.
//  SKID mode adds a second entry, so stall-free full throughput is kept with a registered in_ready.
// PARAMETERS
//  CTRL_W   8    width of control bundle (RegWrite, ResultSrc, Rd, ...); forced 0 on bubble
//  DATA_W   128  width of data bundle (ALUResult, ReadData, ExtImm, PCPlus4, ...)
//  SKID     1    1: two-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  flush      in   1       discard all held entries and the current input (branch mispredict/trap)
//  stall      in   1       hazard-unit freeze: no accept, no emit, contents held
//  in_valid   in   1       upstream entry present
//  in_ready   out  1       stage can accept this cycle
//  in_ctrl    in   CTRL_W  upstream control bundle
//  in_data    in   DATA_W  upstream data bundle
//  out_valid  out  1       entry presented downstream
//  out_ready  in   1       downstream accepts
//  out_ctrl   out  CTRL_W  control of head entry; 0 when out_valid=0
//  out_data   out  DATA_W  data of head entry; unspecified when out_valid=0
//  occupancy  out  2       entries held (0..1 if SKID=0, 0..2 if SKID=1)
// BEHAVIOUR
//  - Storage: head slot H (drives outputs) and, if SKID=1, skid slot S. Each: valid, ctrl, data.
//  - Reset (async): H/S valid=0, ctrl=0, data=0 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0;
//    in_ready=1 right after reset release (unless stall).
//  - accept = in_valid & in_ready & ~flush; emit = out_valid & out_ready & ~stall & ~flush.
//  - in_ready: SKID=1 -> ~S.valid & ~stall (S.valid registered). SKID=0 -> ~stall & (~H.valid | out_ready).
//  - Latency 1 cycle: an entry accepted at edge N is presented on out_* after edge N.
//  - Next state (priority order):
//    1. flush: H.valid, S.valid <- 0; ctrl zeroed; input dropped. Overrides stall and handshakes.
//    2. stall: everything held; out_valid/out_ctrl/out_data unchanged.
//    3. H empty or emit: H <- S if S.valid (S cleared; any accept goes to S), else H <- input if accept,
//       else H.valid <- 0 and H.ctrl <- 0.
//    4. H full, no emit, accept (SKID=1 only): S <- input.
//  - Simultaneous accept+emit with S empty: H replaced by the new entry; occupancy unchanged.
//  - Full (occupancy=2): in_ready=0 next cycle; after one emit H<-S, in_ready=1 the following cycle.
//  - Ordering is strictly FIFO; no entry is duplicated or lost except by flush.
//  - out_ctrl is gated: out_ctrl = H.valid ? H.ctrl : 0, so a bubble never writes RF/memory.
//  - Reset mid-transfer discards all entries immediately; no partial update.
//  - occupancy = H.valid + S.valid; unused S never valid when SKID=0.
//  - Assertion: S.valid implies H.valid.
// STRUCTURE
//  - Shared include pipeline_defs.vh: control-bundle field offsets/widths (REGWRITE_BIT, RESULTSRC_LSB,
//    RD_LSB) and per-stage CTRL_W/DATA_W constants; stage tops pack/unpack bundles with them.
//  - One sub-module pipe_slot: valid+ctrl+data register with async reset, load enable and clear.
//    Instantiated once (H) or twice (H, S via generate on SKID).
//  - All control (accept/emit/select/in_ready) lives in the top.
// TESTING
//  - Reset: rst=1 mid-stream with 2 entries held -> out_valid=0, out_ctrl=0, occupancy=0 asynchronously;
//    in_ready=1 the cycle after release.
//  - Streaming: SKID=1, out_ready=1, in_valid=1, in_data=1,2,3... -> out_data=1,2,3 each cycle,
//    1-cycle latency, occupancy=1 throughout.
//  - Backpressure: out_ready=0 while sending 0xA,0xB -> occupancy=2, in_ready=0; then out_ready=1 ->
//    0xA then 0xB emitted, in_ready returns to 1, no loss or duplicate.
//  - Stall: stall=1 for 3 cycles while H holds ctrl=0x81 -> out_* frozen, in_ready=0, input ignored;
//    release -> normal flow resumes.
//  - Flush: flush=1 with occupancy=2 and in_valid=1, in_ctrl=0xFF (stall=1 too) -> next cycle
//    out_valid=0, out_ctrl=0x00, occupancy=0; flushed input never appears.
//  - SKID=0 build: out_ready toggling 1,0,1 under continuous input -> in_ready follows ~H.valid|out_ready
//    combinationally; occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline register: default bundle
// widths, slot-select encodings and a small occupancy helper.
package pipe_stage_buf_pkg;

  // Default bundle widths for a generic stage
  localparam int unsigned CTRL_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 128;

  // What the head slot does on the next edge
  typedef enum logic [1:0] {
    H_HOLD      = 2'd0,
    H_FROM_SKID = 2'd1,
    H_FROM_IN   = 2'd2,
    H_CLEAR     = 2'd3
  } head_sel_e;

  // What the skid slot does on the next edge
  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_FROM_IN = 2'd1,
    S_CLEAR   = 2'd2
  } skid_sel_e;

  // Number of valid entries across head and skid slots
  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline register: valid bit, control bundle and
// data bundle. A load marks the slot valid; a clear empties it and zeroes the
// control bundle so a bubble can never carry live write-enables.
module pipe_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Slot register: clear wins over load; data is kept on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data bundle is reset too, so out_data reads 0 after reset
      // rather than X; it is a single register, not a memory array.
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      // NOTE: non-blocking assignments keep every slot update on the same
      // edge-sampled values, independent of statement order.
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
// valid/ready handshake, hazard stall and flush. With SKID=1 a second slot
// lets in_ready come straight from a flop while still streaming one entry per
// cycle; with SKID=0 it is a single slot with a combinational in_ready.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              h_valid;
  logic [CTRL_W-1:0] h_ctrl;
  logic [DATA_W-1:0] h_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  head_sel_e head_sel;
  skid_sel_e skid_sel;
  logic      accept;
  logic      emit;

  // Upstream ready: from the skid flop when present, else from head state and out_ready
  always_comb begin
    if (SKID) in_ready = ~s_valid & ~stall;
    else      in_ready = ~stall & (~h_valid | out_ready);
  end

  assign accept = in_valid & in_ready & ~flush;
  assign emit   = h_valid & out_ready & ~stall & ~flush;

  // Slot steering: flush, then stall, then refill head, then park in skid
  always_comb begin
    // NOTE: defaults first so every path assigns both selects and no latch is inferred.
    head_sel = H_HOLD;
    skid_sel = S_HOLD;
    if (flush) begin
      head_sel = H_CLEAR;
      skid_sel = S_CLEAR;
    end else if (stall) begin
      head_sel = H_HOLD;
      skid_sel = S_HOLD;
    end else if (~h_valid | emit) begin
      if (s_valid) begin
        head_sel = H_FROM_SKID;
        skid_sel = accept ? S_FROM_IN : S_CLEAR;
      end else if (accept) begin
        head_sel = H_FROM_IN;
      end else begin
        head_sel = H_CLEAR;
      end
    end else if (accept) begin
      skid_sel = S_FROM_IN;
    end
  end

  pipe_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_head (
    .clk      (clk),
    .rst      (rst),
    .load     ((head_sel == H_FROM_SKID) || (head_sel == H_FROM_IN)),
    .clear    (head_sel == H_CLEAR),
    .load_ctrl((head_sel == H_FROM_SKID) ? s_ctrl : in_ctrl),
    .load_data((head_sel == H_FROM_SKID) ? s_data : in_data),
    .valid    (h_valid),
    .ctrl     (h_ctrl),
    .data     (h_data)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (skid_sel == S_FROM_IN),
      .clear    (skid_sel == S_CLEAR),
      .load_ctrl(in_ctrl),
      .load_data(in_data),
      .valid    (s_valid),
      .ctrl     (s_ctrl),
      .data     (s_data)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_ctrl  = '0;
    assign s_data  = '0;
  end

  assign out_valid = h_valid;
  assign out_ctrl  = h_valid ? h_ctrl : '0;
  assign out_data  = h_data;
  assign occupancy = count_valid(h_valid, s_valid);

  // The skid slot only ever fills behind a held head entry
  skid_implies_head: assert property (@(posedge clk) disable iff (rst) s_valid |-> h_valid);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: a SKID=1 instance driven through
// reset, streaming, backpressure, stall, flush and random traffic, and a
// SKID=0 instance exercised with toggling out_ready. A queue model predicts
// every output; entries are pushed on accept and popped on emit.
module tb_pipe_stage_buf;

  typedef struct {
    logic [7:0]   ctrl;
    logic [127:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst;

  // SKID=1 instance signals
  logic         flush, stall, in_valid, out_ready;
  logic [7:0]   in_ctrl;
  logic [127:0] in_data;
  logic         in_ready, out_valid;
  logic [7:0]   out_ctrl;
  logic [127:0] out_data;
  logic [1:0]   occupancy;

  // SKID=0 instance signals
  logic         flush0, stall0, in_valid0, out_ready0;
  logic [7:0]   in_ctrl0;
  logic [31:0]  in_data0;
  logic         in_ready0, out_valid0;
  logic [7:0]   out_ctrl0;
  logic [31:0]  out_data0;
  logic [1:0]   occupancy0;

  entry_t q[$];
  entry_t q0[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(8), .DATA_W(128), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_buf #(.CTRL_W(8), .DATA_W(32), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .stall(stall0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle on the SKID=1 instance: drive, compare against the model, clock, update model
  task automatic step(input logic iv, input logic [7:0] ic, input logic [127:0] id,
                      input logic ordy, input logic stl, input logic fl);
    logic   exp_ready, acc, em;
    entry_t e;
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; stall = stl; flush = fl;
    #1;
    exp_ready = ~stl & (q.size() < 2);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, q.size() > 0);
    check("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].ctrl : 8'h00);
    if (q.size() > 0) check("out_data", out_data, q[0].data);
    check("occupancy", occupancy, q.size());
    acc = iv & exp_ready & ~fl;
    em  = (q.size() > 0) & ordy & ~stl & ~fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (em) void'(q.pop_front());
      if (acc) begin
        e.ctrl = ic;
        e.data = id;
        q.push_back(e);
      end
    end
  endtask

  // One cycle on the SKID=0 instance
  task automatic step0(input logic iv, input logic [7:0] ic, input logic [31:0] id,
                       input logic ordy, input logic stl, input logic fl);
    logic   exp_ready, acc, em;
    entry_t e;
    in_valid0 = iv; in_ctrl0 = ic; in_data0 = id; out_ready0 = ordy; stall0 = stl; flush0 = fl;
    #1;
    exp_ready = ~stl & ((q0.size() == 0) | ordy);
    check("in_ready0", in_ready0, exp_ready);
    check("out_valid0", out_valid0, q0.size() > 0);
    check("out_ctrl0", out_ctrl0, (q0.size() > 0) ? q0[0].ctrl : 8'h00);
    if (q0.size() > 0) check("out_data0", out_data0, q0[0].data);
    check("occupancy0", occupancy0, q0.size());
    acc = iv & exp_ready & ~fl;
    em  = (q0.size() > 0) & ordy & ~stl & ~fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q0.delete();
    end else begin
      if (em) void'(q0.pop_front());
      if (acc) begin
        e.ctrl = ic;
        e.data = {96'd0, id};
        q0.push_back(e);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 0; stall = 0; in_valid = 0; out_ready = 0; in_ctrl = 0; in_data = 0;
    flush0 = 0; stall0 = 0; in_valid0 = 0; out_ready0 = 0; in_ctrl0 = 0; in_data0 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl", out_ctrl, 8'h00);
    check("rst_out_data", out_data, 128'd0);
    check("rst_occupancy", occupancy, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming: one entry per cycle, occupancy stays at 1
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i + 8'h10), 128'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure: 0xA, 0xB fill both slots, third entry must wait
    step(1'b1, 8'h0A, 128'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 128'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 128'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 128'hC, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);

    // Stall: head holds ctrl 0x81, three frozen cycles with input offered
    step(1'b1, 8'h81, 128'h81, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 128'h55, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h66, 128'h66, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);

    // Flush with two held entries, stall and a live 0xFF input
    step(1'b1, 8'h21, 128'h21, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 128'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 128'hFF, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with two entries held: outputs drop before any clock edge
    step(1'b1, 8'h31, 128'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h32, 128'h32, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_ctrl", out_ctrl, 8'h00);
    check("arst_occupancy", occupancy, 2'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h41, 128'h41, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 128'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional stall and flush
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    // SKID=0 instance: out_ready toggles 1,0,1 under continuous input
    step0(1'b1, 8'h01, 32'h101, 1'b1, 1'b0, 1'b0);
    step0(1'b1, 8'h02, 32'h102, 1'b1, 1'b0, 1'b0);
    step0(1'b1, 8'h03, 32'h103, 1'b0, 1'b0, 1'b0);
    step0(1'b1, 8'h03, 32'h103, 1'b1, 1'b0, 1'b0);
    step0(1'b1, 8'h04, 32'h104, 1'b0, 1'b0, 1'b0);
    step0(1'b1, 8'h04, 32'h104, 1'b1, 1'b1, 1'b0);
    step0(1'b1, 8'h05, 32'h105, 1'b1, 1'b0, 1'b1);
    step0(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
    step0(1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
